// File: rtl/keyboard_matrix.sv
// PS/2 keyboard receiver that maintains a 10x6 key matrix (plus SHIFT/CTRL/REPT) for a PIA row scan.
// Latency: scan_valid/frame_err appear the cycle after the stop-bit edge is seen; cols reflects a key one cycle after scan_valid.
// Backpressure: none; every accepted byte is decoded immediately, and the PS/2 device is never held off.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   ps2_clk, ps2_data       raw PS/2 lines, asynchronous to clk
//   row[3:0]                row select from the PIA; cols[7:0] is the combinational, active-low answer
//   rept_n                  REPT key, active-low
//   scan_code, scan_valid   last good byte and its one-cycle strobe
//   frame_err               one-cycle strobe on parity, stop or timeout error
module keyboard_matrix #(
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] row,
    output logic [7:0] cols,
    output logic       rept_n,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] r;
        logic [2:0] c;
    } key_pos_t;

    // ------------------------------------------------------------------
    // Synchronisers. The clock chain resets high (idle level) so that
    // reset release never manufactures a falling edge.
    // ------------------------------------------------------------------
    logic ps2_clk_meta, ps2_clk_sync, ps2_clk_prev;
    logic ps2_data_meta, ps2_data_sync;
    logic ps2_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2_clk_meta  <= 1'b1;
            ps2_clk_sync  <= 1'b1;
            ps2_clk_prev  <= 1'b1;
            ps2_data_meta <= 1'b1;
            ps2_data_sync <= 1'b1;
        end else begin
            ps2_clk_meta  <= ps2_clk;
            ps2_clk_sync  <= ps2_clk_meta;
            ps2_clk_prev  <= ps2_clk_sync;
            ps2_data_meta <= ps2_data;
            ps2_data_sync <= ps2_data_meta;
        end
    end

    assign ps2_fall = ps2_clk_prev & ~ps2_clk_sync;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t       rx_state, rx_state_nxt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            parity_bit;
    logic [TW-1:0]   tmo_cnt;
    logic            stop_ok, stop_bad, tmo_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_state_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        stop_ok      = 1'b0;
        stop_bad     = 1'b0;
        tmo_hit      = 1'b0;
        if (ps2_fall) begin
            case (rx_state)
                RX_IDLE: begin
                    if (!ps2_data_sync) begin
                        rx_state_nxt = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == 3'd7) begin
                        rx_state_nxt = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    rx_state_nxt = RX_STOP;
                end
                RX_STOP: begin
                    rx_state_nxt = RX_IDLE;
                    // Odd parity: data plus parity bit must hold an odd number of ones.
                    if ((^{shift_reg, parity_bit}) && ps2_data_sync) begin
                        stop_ok = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
                default: rx_state_nxt = RX_IDLE;
            endcase
        end else if (rx_state != RX_IDLE && tmo_cnt == TMO_LAST) begin
            rx_state_nxt = RX_IDLE;
            tmo_hit      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            tmo_cnt    <= '0;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= stop_ok;
            frame_err  <= stop_bad | tmo_hit;
            if (stop_ok) begin
                scan_code <= shift_reg;
            end

            if (ps2_fall) begin
                case (rx_state)
                    RX_IDLE:   bit_cnt <= 3'd0;
                    RX_DATA: begin
                        shift_reg <= {ps2_data_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: parity_bit <= ps2_data_sync;
                    default:   ;
                endcase
            end

            if (ps2_fall || rx_state == RX_IDLE || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan code to matrix position. Extended prefix is ignored for these.
    // ------------------------------------------------------------------
    function automatic key_pos_t mk(input logic [3:0] r, input logic [2:0] c);
        key_pos_t p;
        p.hit = 1'b1;
        p.r   = r;
        p.c   = c;
        return p;
    endfunction

    function automatic key_pos_t key_lookup(input logic [7:0] code);
        key_pos_t p;
        p = '0;
        case (code)
            // row 0: 1 2 3 4 5 6
            8'h16: p = mk(4'd0, 3'd0);  8'h1E: p = mk(4'd0, 3'd1);
            8'h26: p = mk(4'd0, 3'd2);  8'h25: p = mk(4'd0, 3'd3);
            8'h2E: p = mk(4'd0, 3'd4);  8'h36: p = mk(4'd0, 3'd5);
            // row 1: 7 8 9 0 - =
            8'h3D: p = mk(4'd1, 3'd0);  8'h3E: p = mk(4'd1, 3'd1);
            8'h46: p = mk(4'd1, 3'd2);  8'h45: p = mk(4'd1, 3'd3);
            8'h4E: p = mk(4'd1, 3'd4);  8'h55: p = mk(4'd1, 3'd5);
            // row 2: Q W E R T Y
            8'h15: p = mk(4'd2, 3'd0);  8'h1D: p = mk(4'd2, 3'd1);
            8'h24: p = mk(4'd2, 3'd2);  8'h2D: p = mk(4'd2, 3'd3);
            8'h2C: p = mk(4'd2, 3'd4);  8'h35: p = mk(4'd2, 3'd5);
            // row 3: U I O P A S
            8'h3C: p = mk(4'd3, 3'd0);  8'h43: p = mk(4'd3, 3'd1);
            8'h44: p = mk(4'd3, 3'd2);  8'h4D: p = mk(4'd3, 3'd3);
            8'h1C: p = mk(4'd3, 3'd4);  8'h1B: p = mk(4'd3, 3'd5);
            // row 4: D F G H J K
            8'h23: p = mk(4'd4, 3'd0);  8'h2B: p = mk(4'd4, 3'd1);
            8'h34: p = mk(4'd4, 3'd2);  8'h33: p = mk(4'd4, 3'd3);
            8'h3B: p = mk(4'd4, 3'd4);  8'h42: p = mk(4'd4, 3'd5);
            // row 5: L ; ' Z X C
            8'h4B: p = mk(4'd5, 3'd0);  8'h4C: p = mk(4'd5, 3'd1);
            8'h52: p = mk(4'd5, 3'd2);  8'h1A: p = mk(4'd5, 3'd3);
            8'h22: p = mk(4'd5, 3'd4);  8'h21: p = mk(4'd5, 3'd5);
            // row 6: V RETURN B N M ,
            8'h2A: p = mk(4'd6, 3'd0);  8'h5A: p = mk(4'd6, 3'd1);
            8'h32: p = mk(4'd6, 3'd2);  8'h31: p = mk(4'd6, 3'd3);
            8'h3A: p = mk(4'd6, 3'd4);  8'h41: p = mk(4'd6, 3'd5);
            // row 7: . / [ ] \ `
            8'h49: p = mk(4'd7, 3'd0);  8'h4A: p = mk(4'd7, 3'd1);
            8'h54: p = mk(4'd7, 3'd2);  8'h5B: p = mk(4'd7, 3'd3);
            8'h5D: p = mk(4'd7, 3'd4);  8'h0E: p = mk(4'd7, 3'd5);
            // row 8: ESC BKSP TAB LEFT RIGHT F1
            8'h76: p = mk(4'd8, 3'd0);  8'h66: p = mk(4'd8, 3'd1);
            8'h0D: p = mk(4'd8, 3'd2);  8'h6B: p = mk(4'd8, 3'd3);
            8'h74: p = mk(4'd8, 3'd4);  8'h05: p = mk(4'd8, 3'd5);
            // row 9: SPACE UP DOWN F2 F3 F4
            8'h29: p = mk(4'd9, 3'd0);  8'h75: p = mk(4'd9, 3'd1);
            8'h72: p = mk(4'd9, 3'd2);  8'h06: p = mk(4'd9, 3'd3);
            8'h04: p = mk(4'd9, 3'd4);  8'h0C: p = mk(4'd9, 3'd5);
            default: p = '0;
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Decoder: acts on the registered byte, so the matrix changes on the
    // edge that ends the scan_valid cycle.
    // ------------------------------------------------------------------
    logic [5:0] matrix [10];
    logic       lshift, rshift, ctrl, rept;
    logic       brk_flag, ext_flag;
    key_pos_t   key;

    always_comb begin
        key = key_lookup(scan_code);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 10; i++) begin
                matrix[i] <= 6'h00;
            end
            lshift   <= 1'b0;
            rshift   <= 1'b0;
            ctrl     <= 1'b0;
            rept     <= 1'b0;
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
        end else if (scan_valid) begin
            if (scan_code == 8'hF0) begin
                brk_flag <= 1'b1;
            end else if (scan_code == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (scan_code == 8'hAA && !brk_flag && !ext_flag) begin
                // Keyboard self-test pass: treat as a fresh keyboard.
                for (int i = 0; i < 10; i++) begin
                    matrix[i] <= 6'h00;
                end
                lshift   <= 1'b0;
                rshift   <= 1'b0;
                ctrl     <= 1'b0;
                rept     <= 1'b0;
            end else begin
                brk_flag <= 1'b0;
                ext_flag <= 1'b0;
                case (scan_code)
                    // E0 12 / E0 59 are fake shifts around PrintScreen etc.
                    8'h12: if (!ext_flag) lshift <= ~brk_flag;
                    8'h59: if (!ext_flag) rshift <= ~brk_flag;
                    8'h14: ctrl <= ~brk_flag;
                    8'h11: rept <= ~brk_flag;
                    default: begin
                        if (key.hit) begin
                            matrix[key.r][key.c] <= ~brk_flag;
                        end
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Row scan outputs
    // ------------------------------------------------------------------
    logic [5:0] col_lines;

    always_comb begin
        col_lines = 6'h3F;
        for (int i = 0; i < 10; i++) begin
            if (row == 4'(i)) begin
                col_lines = ~matrix[i];
            end
        end
    end

    assign cols   = {~(lshift | rshift), ~ctrl, col_lines};
    assign rept_n = ~rept;

endmodule

// File: tb/tb_keyboard_matrix.sv
module tb_keyboard_matrix;

    localparam int TMO  = 200;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] row = 4'd0;
    logic [7:0] cols;
    logic       rept_n;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    keyboard_matrix #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .row        (row),
        .cols       (cols),
        .rept_n     (rept_n),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Key table, index = row*6 + col.
    byte unsigned keymap [60] = '{
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35,
        8'h3C, 8'h43, 8'h44, 8'h4D, 8'h1C, 8'h1B,
        8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
        8'h4B, 8'h4C, 8'h52, 8'h1A, 8'h22, 8'h21,
        8'h2A, 8'h5A, 8'h32, 8'h31, 8'h3A, 8'h41,
        8'h49, 8'h4A, 8'h54, 8'h5B, 8'h5D, 8'h0E,
        8'h76, 8'h66, 8'h0D, 8'h6B, 8'h74, 8'h05,
        8'h29, 8'h75, 8'h72, 8'h06, 8'h04, 8'h0C
    };
    byte unsigned mods    [4] = '{8'h12, 8'h59, 8'h14, 8'h11};
    byte unsigned unmaps  [4] = '{8'h00, 8'hFF, 8'h03, 8'h77};

    // Reference keyboard state
    bit         pressed [60];
    bit         m_lsh, m_rsh, m_ctl, m_rpt, m_brk, m_ext;
    logic [7:0] exp_q [$];
    int         exp_err = 0;
    bit         row_rand = 1'b0;
    logic [7:0] e;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        foreach (pressed[i]) pressed[i] = 1'b0;
        m_lsh = 0; m_rsh = 0; m_ctl = 0; m_rpt = 0; m_brk = 0; m_ext = 0;
    endtask

    task automatic apply(input logic [7:0] b);
        if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hAA && !m_brk && !m_ext) begin
            clear_model();
        end else begin
            if (b == 8'h12) begin
                if (!m_ext) m_lsh = !m_brk;
            end else if (b == 8'h59) begin
                if (!m_ext) m_rsh = !m_brk;
            end else if (b == 8'h14) begin
                m_ctl = !m_brk;
            end else if (b == 8'h11) begin
                m_rpt = !m_brk;
            end else begin
                for (int i = 0; i < 60; i++)
                    if (keymap[i] == b) pressed[i] = !m_brk;
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    function automatic logic [7:0] model_cols(input logic [3:0] r);
        logic [7:0] v;
        v[7] = ~(m_lsh | m_rsh);
        v[6] = ~m_ctl;
        for (int c = 0; c < 6; c++)
            v[c] = (r < 4'd10) ? ~pressed[int'(r) * 6 + c] : 1'b1;
        return v;
    endfunction

    // Per-cycle comparison against the reference state.
    initial begin
        clear_model();
        forever begin
            @(negedge clk);
            check8("cols", cols, model_cols(row));
            check8("rept_n", {7'b0, rept_n}, {7'b0, ~m_rpt});
            if (frame_err === 1'b1) begin
                total++;
                if (exp_err == 0) begin
                    bad++;
                    $display("FAIL frame_err: unexpected pulse at %0t", $time);
                end else begin
                    exp_err--;
                end
            end
            if (scan_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scan_valid: unexpected strobe code %02h at %0t", scan_code, $time);
                end else begin
                    e = exp_q.pop_front();
                    check8("scan_code", scan_code, e);
                    apply(e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (row_rand) row = 4'($urandom_range(0, 15));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of an 11-bit frame: start, 8 data LSB first, parity, stop.
    task automatic send_raw(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_pending();
        check8("pending_bytes", 8'(exp_q.size()), 8'd0);
        check8("pending_errs", 8'(exp_err), 8'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        send_raw(b, 1'b0, 1'b0, 11);
        tick(30);
        check_pending();
    endtask

    task automatic look(input logic [3:0] r);
        row = r;
        @(negedge clk);
    endtask

    initial begin
        int k;
        logic [7:0] b;
        // Reset state
        tick(5);
        look(4'd0);
        check8("rst_cols", cols, 8'hFF);
        check8("rst_rept_n", {7'b0, rept_n}, 8'h01);
        check8("rst_scan_code", scan_code, 8'h00);
        check8("rst_strobes", {6'b0, scan_valid, frame_err}, 8'h00);
        tick(1);
        reset_n = 1'b1;
        tick(5);

        // A make / break at row 3
        look(4'd3);
        send_byte(8'h1C);
        look(4'd3);
        check8("a_make", cols, 8'hEF);
        send_byte(8'hF0);
        send_byte(8'h1C);
        look(4'd3);
        check8("a_break", cols, 8'hFF);

        // Shifts, seen on an out-of-range row
        send_byte(8'h12);
        look(4'd15);
        check8("lshift_make", cols, 8'h7F);
        send_byte(8'h59);
        send_byte(8'hF0);
        send_byte(8'h12);
        look(4'd15);
        check8("shift_held", {7'b0, cols[7]}, 8'h00);
        send_byte(8'hF0);
        send_byte(8'h59);
        look(4'd15);
        check8("shift_free", cols, 8'hFF);

        // Bad parity
        exp_err = 1;
        send_raw(8'h1C, 1'b1, 1'b0, 11);
        tick(30);
        check_pending();
        look(4'd3);
        check8("bad_parity_cols", cols, 8'hFF);

        // Timeout after start + 3 data bits, then a good space
        exp_err = 1;
        send_raw(8'h29, 1'b0, 1'b0, 4);
        tick(TMO + 30);
        check_pending();
        send_byte(8'h29);
        look(4'd9);
        check8("space_cols", cols, 8'hFE);

        // CTRL, REPT, RETURN then self-test clear
        send_byte(8'h14);
        send_byte(8'h11);
        send_byte(8'h5A);
        look(4'd6);
        check8("ctrl_ret_cols", cols, 8'hBD);
        check8("rept_on", {7'b0, rept_n}, 8'h00);
        send_byte(8'hAA);
        look(4'd6);
        check8("aa_row6", cols, 8'hFF);
        check8("aa_rept", {7'b0, rept_n}, 8'h01);
        look(4'd9);
        check8("aa_row9", cols, 8'hFF);

        // Reset in the middle of a frame
        send_byte(8'h1C);
        send_raw(8'h5A, 1'b0, 1'b0, 5);
        tick(2);
        reset_n = 1'b0;
        clear_model();
        tick(3);
        look(4'd3);
        check8("midrst_cols", cols, 8'hFF);
        check8("midrst_scan_code", scan_code, 8'h00);
        check8("midrst_rept_n", {7'b0, rept_n}, 8'h01);
        tick(1);
        reset_n = 1'b1;
        tick(20);
        check_pending();
        send_byte(8'h5A);
        look(4'd6);
        check8("after_rst_ret", cols, 8'hFD);

        // Randomized traffic
        row_rand = 1'b1;
        for (int n = 0; n < 120; n++) begin
            k = $urandom_range(0, 99);
            if (k < 45)      send_byte(keymap[$urandom_range(0, 59)]);
            else if (k < 60) send_byte(mods[$urandom_range(0, 3)]);
            else if (k < 75) send_byte(8'hF0);
            else if (k < 82) send_byte(8'hE0);
            else if (k < 88) send_byte(unmaps[$urandom_range(0, 3)]);
            else if (k < 91) send_byte(8'hAA);
            else begin
                b = 8'($urandom_range(0, 255));
                exp_err = 1;
                if (k < 96) send_raw(b, 1'b1, 1'b0, 11);
                else        send_raw(b, 1'b0, 1'b1, 11);
                tick(30);
                check_pending();
            end
        end
        tick(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        bad++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
